// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
// Shared widths, FSM state type and the skid-buffer word type for the
// read-side burst engine of the async FIFO.
//   DATA_WIDTH : FIFO word width
//   ADDR_WIDTH : FIFO address width, depth = 2**ADDR_WIDTH
//   LEN_WIDTH  : burst length width, wide enough to hold a full-depth burst
package fifo_rd_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 6;
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } rd_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } rd_word_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid
// Two-entry valid/ready buffer between the FIFO read port and the output
// stream. entry0 is always the head; entry1 only holds a word while the
// buffer is full.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   push        : write push_word this cycle (honoured only when push_ready)
//   push_word   : incoming word
//   push_ready  : registered occupancy is below two
//   pop_valid   : head entry holds a word
//   pop_word    : head entry
//   pop_ready   : downstream accepts the head this cycle
//   count       : registered occupancy, 0..2
module fifo_rd_skid
  import fifo_rd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rd_word_t   push_word,
  output logic       push_ready,
  output logic       pop_valid,
  output rd_word_t   pop_word,
  input  logic       pop_ready,
  output logic [1:0] count
);

  rd_word_t entry0;
  rd_word_t entry1;
  logic     do_push;
  logic     do_pop;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign pop_word   = entry0;
  assign do_push    = push && push_ready;
  assign do_pop     = pop_valid && pop_ready;

  // Occupancy update. With one word held, a simultaneous push and pop
  // replaces the head in place so the stream keeps 1 word/cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (do_push) begin
            entry0 <= push_word;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (do_push && do_pop) begin
            entry0 <= push_word;
          end else if (do_push) begin
            entry1 <= push_word;
            count  <= 2'd2;
          end else if (do_pop) begin
            count  <= 2'd0;
          end
        end
        default: begin
          if (do_pop) begin
            entry0 <= entry1;
            count  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_burst_engine.sv
// fifo_rd_burst_engine
// Read-clock-domain burst controller: accepts a length request, pops that
// many words from a fall-through FIFO read port and forwards them on a
// valid/ready stream with the final word flagged.
// Ports:
//   rclk, rrst          : read clock, synchronous active-high reset
//   req_valid/req_len   : burst request (0..64 words), req_ready while idle
//   rinc/rdata/rempty   : FIFO read port (rdata valid whenever !rempty)
//   m_valid/m_data/
//   m_last/m_ready      : output stream
//   busy                : engine not idle
//   words_read          : FIFO pops in the current burst
//   done                : one-cycle completion pulse
//   csum                : XOR of all words delivered in the burst
//                         (present only when FIFO_RD_CSUM_EN is defined)
module fifo_rd_burst_engine
  import fifo_rd_pkg::*;
(
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  req_valid,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  req_ready,
  output logic                  rinc,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rempty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  words_read,
  output logic                  done
`ifdef FIFO_RD_CSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] csum
`endif
);

  rd_state_t            state;
  rd_state_t            state_next;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 accept;
  logic                 handshake;
  logic                 skid_push_ready;
  logic [1:0]           skid_count;
  rd_word_t             skid_in;
  rd_word_t             skid_head;

  assign handshake = m_valid && m_ready;
  assign busy      = (state != IDLE);
  assign m_data    = skid_head.data;
  assign m_last    = skid_head.last;
  assign skid_in   = '{data: rdata, last: (remaining == LEN_WIDTH'(1))};

  // State register.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and FSM outputs. rinc is held low during a reset cycle so
  // the FIFO never loses a word on the same edge that clears the engine.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rinc       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = (req_len != '0) ? READ : DONE;
        end
      end
      READ: begin
        rinc = !rrst && !rempty && (remaining != '0) && skid_push_ready;
        if (rinc && (remaining == LEN_WIDTH'(1))) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (handshake && m_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst counters. remaining only moves on a pop, so words_read stops at
  // the requested length without any explicit saturation.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      remaining  <= '0;
      words_read <= '0;
    end else if (accept) begin
      remaining  <= req_len;
      words_read <= '0;
    end else if (rinc) begin
      remaining  <= remaining - LEN_WIDTH'(1);
      words_read <= words_read + LEN_WIDTH'(1);
    end
  end

  fifo_rd_skid u_skid (
    .clk        (rclk),
    .rst        (rrst),
    .push       (rinc),
    .push_word  (skid_in),
    .push_ready (skid_push_ready),
    .pop_valid  (m_valid),
    .pop_word   (skid_head),
    .pop_ready  (m_ready),
    .count      (skid_count)
  );

`ifdef FIFO_RD_CSUM_EN
  // Running XOR of delivered words; cleared when a new burst is accepted
  // and otherwise held, so it is still readable after done.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (handshake) begin
      csum <= csum ^ m_data;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_burst_engine.sv
// tb_fifo_rd_burst_engine
// Self-checking bench: a queue-based FIFO feeds the engine, and a
// transaction-level model (pending-word queue plus burst bookkeeping)
// predicts every output on every cycle. Directed scenarios add literal
// expectations on the delivered word sequence.
module tb_fifo_rd_burst_engine;
  import fifo_rd_pkg::*;

  localparam int P_IDLE  = 0;
  localparam int P_READ  = 1;
  localparam int P_FLUSH = 2;
  localparam int P_DONE  = 3;

  logic                  rclk = 1'b0;
  logic                  rrst;
  logic                  req_valid;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  req_ready;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;
  logic                  busy;
  logic [LEN_WIDTH-1:0]  words_read;
  logic                  done;
`ifdef FIFO_RD_CSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif

  always #5 rclk = ~rclk;

  fifo_rd_burst_engine dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .req_valid  (req_valid),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .rinc       (rinc),
    .rdata      (rdata),
    .rempty     (rempty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .words_read (words_read),
    .done       (done)
`ifdef FIFO_RD_CSUM_EN
    ,
    .csum       (csum)
`endif
  );

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } exp_word_t;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_no     = 0;

  // FIFO contents (head at index 0) and the reference model state.
  logic [DATA_WIDTH-1:0] fifo_q[$];
  exp_word_t             out_q[$];
  int                    phase        = P_IDLE;
  int                    remaining_m  = 0;
  int                    words_read_m = 0;
  logic [DATA_WIDTH-1:0] csum_m       = '0;

  // Observations used by the directed literal checks.
  logic [DATA_WIDTH-1:0] hs_data[$];
  logic                  hs_last[$];
  int rinc_cycles, first_rinc, last_rinc, done_cycle, last_hs_cycle, wr_at_done;
  logic [DATA_WIDTH-1:0] csum_at_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle_no, act, exp);
    end
  endtask

  function automatic bit expRinc();
    return (phase == P_READ) && (fifo_q.size() > 0) && (remaining_m > 0) &&
           (out_q.size() < 2) && !rrst;
  endfunction

  // Compare every DUT output with the model for the current cycle.
  task automatic checkOutput();
    check("req_ready", 32'(req_ready), 32'(phase == P_IDLE));
    check("busy", 32'(busy), 32'(phase != P_IDLE));
    check("done", 32'(done), 32'(phase == P_DONE));
    check("rinc", 32'(rinc), 32'(expRinc()));
    check("m_valid", 32'(m_valid), 32'(out_q.size() > 0));
    if (out_q.size() > 0) begin
      check("m_data", 32'(m_data), 32'(out_q[0].data));
      check("m_last", 32'(m_last), 32'(out_q[0].last));
    end
    check("words_read", 32'(words_read), 32'(words_read_m));
`ifdef FIFO_RD_CSUM_EN
    if (phase == P_IDLE || phase == P_DONE)
      check("csum", 32'(csum), 32'(csum_m));
`endif
  endtask

  // Advance the model across the coming clock edge.
  task automatic modelStep(input logic rst, input logic rv, input int len, input logic mr);
    bit        er;
    bit        hs;
    bit        hs_is_last;
    exp_word_t w;
    er = expRinc();
    hs = (out_q.size() > 0) && mr;
    hs_is_last = hs && out_q[0].last;
    if (rst) begin
      phase = P_IDLE;
      out_q.delete();
      remaining_m  = 0;
      words_read_m = 0;
      csum_m       = '0;
      return;
    end
    if (hs) begin
      csum_m ^= out_q[0].data;
      void'(out_q.pop_front());
    end
    if (er) begin
      w.data = fifo_q[0];
      w.last = (remaining_m == 1);
      out_q.push_back(w);
      remaining_m--;
      words_read_m++;
    end
    case (phase)
      P_IDLE: if (rv) begin
        remaining_m  = len;
        words_read_m = 0;
        csum_m       = '0;
        phase        = (len != 0) ? P_READ : P_DONE;
      end
      P_READ:  if (er && remaining_m == 0) phase = P_FLUSH;
      P_FLUSH: if (hs_is_last) phase = P_DONE;
      default: phase = P_IDLE;
    endcase
  endtask

  // One clock cycle: drive inputs (including the FIFO port), check, step.
  task automatic applyStimulus(input logic rst, input logic rv, input int len, input logic mr);
    rrst      = rst;
    req_valid = rv;
    req_len   = LEN_WIDTH'(len);
    m_ready   = mr;
    rempty    = (fifo_q.size() == 0);
    rdata     = rempty ? DATA_WIDTH'($urandom) : fifo_q[0];
    #1;
    checkOutput();
    if (m_valid && m_ready && !rst) begin
      hs_data.push_back(m_data);
      hs_last.push_back(m_last);
      last_hs_cycle = cycle_no;
    end
    if (rinc) begin
      rinc_cycles++;
      if (first_rinc < 0) first_rinc = cycle_no;
      last_rinc = cycle_no;
    end
    if (done) begin
      done_cycle = cycle_no;
      wr_at_done = int'(words_read);
`ifdef FIFO_RD_CSUM_EN
      csum_at_done = csum;
`endif
    end
    modelStep(rst, rv, len, mr);
    if (rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
    @(negedge rclk);
    cycle_no++;
  endtask

  task automatic clearLogs();
    hs_data.delete();
    hs_last.delete();
    rinc_cycles   = 0;
    first_rinc    = -1;
    last_rinc     = -1;
    done_cycle    = -1;
    last_hs_cycle = -1;
    wr_at_done    = -1;
    csum_at_done  = '0;
  endtask

  // Idle cycles with m_ready high until done is seen or the budget runs out.
  task automatic runToDone(input string name, input int budget);
    int n;
    n = 0;
    while (done_cycle < 0 && n < budget) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b1);
      n++;
    end
    check({name, "_done_seen"}, 32'(done_cycle >= 0), 32'd1);
  endtask

  initial begin
    int n;
    int len;
    rrst = 1'b1; req_valid = 1'b0; req_len = '0; m_ready = 1'b0;
    rempty = 1'b1; rdata = '0;
    clearLogs();
    repeat (2) @(posedge rclk);
    @(negedge rclk);

    // Reset state.
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_m_last", 32'(m_last), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);

    // Back-to-back burst of 8 from a preloaded FIFO.
    $display("[TB] burst of 8 with m_ready high");
    for (int i = 0; i < 8; i++) fifo_q.push_back(DATA_WIDTH'(8'h10 + i));
    clearLogs();
    applyStimulus(1'b0, 1'b1, 8, 1'b1);
    runToDone("s1", 100);
    check("s1_count", 32'(hs_data.size()), 32'd8);
    for (int i = 0; i < 8 && i < hs_data.size(); i++) begin
      check("s1_data", 32'(hs_data[i]), 32'h10 + 32'(i));
      check("s1_last", 32'(hs_last[i]), 32'(i == 7));
    end
    check("s1_rinc_count", 32'(rinc_cycles), 32'd8);
    check("s1_rinc_span", 32'(last_rinc - first_rinc + 1), 32'd8);
    check("s1_done_after_last", 32'(done_cycle), 32'(last_hs_cycle + 1));
    check("s1_words_read", 32'(wr_at_done), 32'd8);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);

    // Burst of 4 with only 2 words present; the rest arrive later.
    $display("[TB] burst stalled on empty FIFO");
    fifo_q.push_back(8'h30);
    fifo_q.push_back(8'h31);
    clearLogs();
    applyStimulus(1'b0, 1'b1, 4, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 0, 1'b1);
    fifo_q.push_back(8'h32);
    fifo_q.push_back(8'h33);
    runToDone("s2", 100);
    check("s2_count", 32'(hs_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < hs_data.size(); i++)
      check("s2_data", 32'(hs_data[i]), 32'h30 + 32'(i));
    check("s2_rinc_count", 32'(rinc_cycles), 32'd4);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);

    // Full FIFO with m_ready cycling 1,0,0,1.
    $display("[TB] full FIFO with m_ready pattern 1,0,0,1");
    for (int i = 0; i < 64; i++) fifo_q.push_back(DATA_WIDTH'(8'h40 + i));
    clearLogs();
    applyStimulus(1'b0, 1'b1, 64, 1'b1);
    n = 0;
    while (done_cycle < 0 && n < 1000) begin
      applyStimulus(1'b0, 1'b0, 0, ((n % 4) == 0) || ((n % 4) == 3));
      n++;
    end
    check("s3_done_seen", 32'(done_cycle >= 0), 32'd1);
    check("s3_count", 32'(hs_data.size()), 32'd64);
    for (int i = 0; i < 64 && i < hs_data.size(); i++)
      check("s3_data", 32'(hs_data[i]), 32'h40 + 32'(i));
    applyStimulus(1'b0, 1'b0, 0, 1'b1);

    // Zero-length request.
    $display("[TB] zero-length request");
    fifo_q.push_back(8'h55);
    clearLogs();
    applyStimulus(1'b0, 1'b1, 0, 1'b1);
    runToDone("s4", 10);
    check("s4_rinc_count", 32'(rinc_cycles), 32'd0);
    check("s4_words", 32'(hs_data.size()), 32'd0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    fifo_q.delete();

    // Reset after three pops of an 8-word burst, then a fresh burst of 2.
    $display("[TB] reset in the middle of a burst");
    for (int i = 0; i < 8; i++) fifo_q.push_back(DATA_WIDTH'(8'h20 + i));
    clearLogs();
    applyStimulus(1'b0, 1'b1, 8, 1'b1);
    n = 0;
    while (words_read != LEN_WIDTH'(3) && n < 20) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b1);
      n++;
    end
    check("s5_reached_3", 32'(words_read), 32'd3);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    check("s5_req_ready", 32'(req_ready), 32'd1);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_m_valid", 32'(m_valid), 32'd0);
    check("s5_m_data", 32'(m_data), 32'd0);
    check("s5_words_read", 32'(words_read), 32'd0);
    clearLogs();
    applyStimulus(1'b0, 1'b1, 2, 1'b1);
    runToDone("s5", 20);
    check("s5_count", 32'(hs_data.size()), 32'd2);
    for (int i = 0; i < 2 && i < hs_data.size(); i++)
      check("s5_data", 32'(hs_data[i]), 32'h23 + 32'(i));
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    fifo_q.delete();

`ifdef FIFO_RD_CSUM_EN
    // Checksum over A5, 3C, FF.
    $display("[TB] checksum burst");
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hFF);
    clearLogs();
    applyStimulus(1'b0, 1'b1, 3, 1'b1);
    runToDone("s6", 20);
    check("s6_csum", 32'(csum_at_done), 32'h66);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
`endif

    // Randomized bursts with random writes, back-pressure and stray requests.
    $display("[TB] randomized bursts");
    for (int b = 0; b < 20; b++) begin
      len = int'($urandom_range(0, 64));
      clearLogs();
      applyStimulus(1'b0, 1'b1, len, 1'($urandom));
      n = 0;
      while (done_cycle < 0 && n < 2000) begin
        if (fifo_q.size() < 64 && $urandom_range(0, 1) == 1)
          fifo_q.push_back(DATA_WIDTH'($urandom));
        applyStimulus(1'b0, 1'($urandom), int'($urandom_range(0, 64)),
                      $urandom_range(0, 3) != 0);
        n++;
      end
      check("rand_done_seen", 32'(done_cycle >= 0), 32'd1);
      check("rand_count", 32'(hs_data.size()), 32'(len));
      applyStimulus(1'b0, 1'b0, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
